// File: rtl/prm_scan_pkg.sv
// Shared types and helpers for the PRM check-stage scan sequencer.
package prm_scan_pkg;

  localparam int unsigned XW_D  = 4;
  localparam int unsigned YW_D  = 5;
  localparam int unsigned ZW_D  = 5;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PUSH,
    FIN
  } scan_state_e;

  // One step of the result signature: rotate left by one, then fold in the beat.
  function automatic logic [31:0] misr_step(input logic [31:0] sig_q, input logic [31:0] data);
    return {sig_q[30:0], sig_q[31]} ^ data;
  endfunction

endpackage

// File: rtl/prm_scan_coord_cnt.sv
// Packed {x,y,z} coordinate counter; z is the fastest index, so a plain +1 suffices.
module prm_scan_coord_cnt
  import prm_scan_pkg::*;
#(
  parameter int unsigned W = XW_D + YW_D + ZW_D
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] coord,
  output logic         last_c
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      coord <= '0;
    end else if (inc) begin
      coord <= coord + W'(1);
    end
  end

  assign last_c = &coord;

endmodule

// File: rtl/prm_xyz_scan_seq.sv
// Exhaustive (x,y,z) stimulus sequencer for prm_chk_v1_0 with valid/ready result output.
// Define PRM_SCAN_MISR_EN to add the sig result-signature output.
module prm_xyz_scan_seq
  import prm_scan_pkg::*;
#(
  parameter int unsigned XW     = XW_D,
  parameter int unsigned YW     = YW_D,
  parameter int unsigned ZW     = ZW_D,
  parameter int unsigned SETTLE = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [2:0]          sel1_cfg,
  input  logic [7:0]          sel2_cfg,
  output logic [2:0]          sel1,
  output logic [7:0]          sel2,
  output logic [XW+YW+ZW-1:0] xyzInput,
  input  logic [31:0]         result_imp,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [XW+YW+ZW-1:0] res_xyz,
  output logic [31:0]         res_data,
`ifdef PRM_SCAN_MISR_EN
  output logic [31:0]         sig,
`endif
  output logic                busy,
  output logic                done
);

  localparam int unsigned CW = XW + YW + ZW;

  scan_state_e      state;
  logic [CNT_W-1:0] settle_cnt;
  logic [CW-1:0]    coord;
  logic             coord_last;
  logic             coord_clr;
  logic             coord_inc;
  logic             beat_acc;

  assign beat_acc  = (state == PUSH) && res_valid && res_ready;
  assign coord_clr = (state == IDLE) && start;
  assign coord_inc = beat_acc && !coord_last;

  prm_scan_coord_cnt #(.W(CW)) u_coord (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (coord_clr),
    .inc    (coord_inc),
    .coord  (coord),
    .last_c (coord_last)
  );

  // Sweep control: issue a coordinate, wait SETTLE cycles, sample, hand off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      settle_cnt <= '0;
      sel1       <= '0;
      sel2       <= '0;
      xyzInput   <= '0;
      res_valid  <= 1'b0;
      res_xyz    <= '0;
      res_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PRM_SCAN_MISR_EN
      sig        <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sel1  <= sel1_cfg;
            sel2  <= sel2_cfg;
            busy  <= 1'b1;
            state <= ISSUE;
`ifdef PRM_SCAN_MISR_EN
            sig   <= '0;
`endif
          end
        end
        ISSUE: begin
          xyzInput   <= coord;
          settle_cnt <= CNT_W'(SETTLE - 1);
          state      <= WAIT;
        end
        WAIT: begin
          if (settle_cnt == '0) begin
            res_data  <= result_imp;
            res_xyz   <= coord;
            res_valid <= 1'b1;
            state     <= PUSH;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        PUSH: begin
          if (beat_acc) begin
            res_valid <= 1'b0;
`ifdef PRM_SCAN_MISR_EN
            sig       <= misr_step(sig, res_data);
`endif
            if (coord_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              state <= ISSUE;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_xyz_scan_seq.sv
// Directed self-checking bench for prm_xyz_scan_seq (small 1/1/1 sweep and default-width sweep).
module tb_prm_xyz_scan_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small instance: XW=YW=ZW=1, SETTLE=2
  logic        start_s, ready_s, misr_mode;
  logic [2:0]  sel1_cfg_s, sel1_s;
  logic [7:0]  sel2_cfg_s, sel2_s;
  logic [2:0]  xyz_s, res_xyz_s;
  logic [31:0] imp_s, res_data_s;
  logic        res_valid_s, busy_s, done_s;
`ifdef PRM_SCAN_MISR_EN
  logic [31:0] sig_s, sig_d;
`endif

  assign imp_s = misr_mode ? 32'h1 : {29'b0, xyz_s};

  prm_xyz_scan_seq #(.XW(1), .YW(1), .ZW(1), .SETTLE(2)) dut_s (
    .CLK(clk), .RST(rst), .start(start_s), .sel1_cfg(sel1_cfg_s), .sel2_cfg(sel2_cfg_s),
    .sel1(sel1_s), .sel2(sel2_s), .xyzInput(xyz_s), .result_imp(imp_s),
    .res_valid(res_valid_s), .res_ready(ready_s), .res_xyz(res_xyz_s), .res_data(res_data_s),
`ifdef PRM_SCAN_MISR_EN
    .sig(sig_s),
`endif
    .busy(busy_s), .done(done_s)
  );

  // Default instance: 4/5/5, SETTLE=3, fed by a two-register check-stage model
  logic        start_d, ready_d;
  logic [2:0]  sel1_cfg_d, sel1_d;
  logic [7:0]  sel2_cfg_d, sel2_d;
  logic [13:0] xyz_d, res_xyz_d;
  logic [31:0] imp_d, res_data_d, chk_p1;
  logic        res_valid_d, busy_d, done_d;

  function automatic logic [31:0] model(input logic [13:0] v);
    return {2'b10, v, ~v, 2'b01};
  endfunction

  always @(posedge clk) begin
    chk_p1 <= model(xyz_d);
    imp_d  <= chk_p1;
  end

  prm_xyz_scan_seq #(.XW(4), .YW(5), .ZW(5), .SETTLE(3)) dut_d (
    .CLK(clk), .RST(rst), .start(start_d), .sel1_cfg(sel1_cfg_d), .sel2_cfg(sel2_cfg_d),
    .sel1(sel1_d), .sel2(sel2_d), .xyzInput(xyz_d), .result_imp(imp_d),
    .res_valid(res_valid_d), .res_ready(ready_d), .res_xyz(res_xyz_d), .res_data(res_data_d),
`ifdef PRM_SCAN_MISR_EN
    .sig(sig_d),
`endif
    .busy(busy_d), .done(done_d)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid_s();
    int t = 0;
    while (!res_valid_s && t < 40) begin
      step();
      t++;
    end
    if (!res_valid_s) chk("s_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid_d();
    int t = 0;
    while (!res_valid_d && t < 60) begin
      step();
      t++;
    end
    if (!res_valid_d) chk("d_valid_timeout", 64'd0, 64'd1);
  endtask

  // Full 8-beat sweep of the small instance
  task automatic run_small();
    int last_cyc = 0;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    chk("s_busy_start", 64'(busy_s), 64'd1);
    chk("s_sel1", 64'(sel1_s), 64'd1);
    chk("s_sel2", 64'(sel2_s), 64'h3C);
`ifdef PRM_SCAN_MISR_EN
    chk("s_sig_clr", 64'(sig_s), 64'd0);
`endif
    for (int n = 0; n < 8; n++) begin
      wait_valid_s();
      chk("s_xyz", 64'(res_xyz_s), 64'(n));
      if (!misr_mode) chk("s_data", 64'(res_data_s), 64'(n));
      if (n > 0) chk("s_gap", 64'(cyc - last_cyc), 64'd4);
      last_cyc = cyc;
      chk("s_done_early", 64'(done_s), 64'd0);
      step();
    end
    chk("s_done", 64'(done_s), 64'd1);
    chk("s_busy_fin", 64'(busy_s), 64'd0);
    step();
    chk("s_done_pulse", 64'(done_s), 64'd0);
    chk("s_busy_after", 64'(busy_s), 64'd0);
  endtask

  initial begin
    int last_cyc;
    rst = 1'b1;
    start_s = 1'b0; start_d = 1'b0;
    ready_s = 1'b1; ready_d = 1'b1;
    misr_mode = 1'b0;
    sel1_cfg_s = 3'd1; sel2_cfg_s = 8'h3C;
    sel1_cfg_d = 3'd2; sel2_cfg_d = 8'h5A;
    repeat (3) step();
    chk("rst_valid", 64'(res_valid_d), 64'd0);
    chk("rst_busy", 64'(busy_d), 64'd0);
    chk("rst_done", 64'(done_d), 64'd0);
    chk("rst_xyz", 64'(xyz_d), 64'd0);
    chk("rst_sel", 64'({sel1_d, sel2_d}), 64'd0);
    chk("rst_res", 64'({res_xyz_d, res_data_d}), 64'd0);
    chk("rst_s_busy", 64'(busy_s), 64'd0);
    rst = 1'b0;
    step();

    run_small();

`ifdef PRM_SCAN_MISR_EN
    misr_mode = 1'b1;
    run_small();
    chk("s_sig", 64'(sig_s), 64'h0000_00FF);
    step();
    chk("s_sig_hold", 64'(sig_s), 64'h0000_00FF);
    misr_mode = 1'b0;
`endif

    // Default-width sweep up to coordinate 0x122, with a stall and an ignored restart
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    chk("d_busy", 64'(busy_d), 64'd1);
    chk("d_sel1", 64'(sel1_d), 64'd2);
    last_cyc = 0;
    for (int n = 0; n <= 'h122; n++) begin
      wait_valid_d();
      chk("d_xyz", 64'(res_xyz_d), 64'(n));
      chk("d_data", 64'(res_data_d), 64'(model(14'(n))));
      if (n > 0) chk("d_gap", 64'(cyc - last_cyc), (n == 6) ? 64'd15 : 64'd5);
      last_cyc = cyc;
      if (n == 5) begin
        ready_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
          step();
          chk("d_stall_valid", 64'(res_valid_d), 64'd1);
          chk("d_stall_xyz", 64'(res_xyz_d), 64'd5);
          chk("d_stall_data", 64'(res_data_d), 64'(model(14'd5)));
        end
        ready_d = 1'b1;
      end
      if (n == 10) begin
        start_d = 1'b1;
        sel1_cfg_d = 3'd5;
        sel2_cfg_d = 8'hFF;
      end
      step();
      start_d = 1'b0;
      if (n == 10) begin
        chk("d_sel1_hold", 64'(sel1_d), 64'd2);
        chk("d_sel2_hold", 64'(sel2_d), 64'h5A);
      end
    end

    // Reset while waiting on coordinate 0x123
    step();
    chk("d_wait_xyz", 64'(xyz_d), 64'h123);
    chk("d_wait_valid", 64'(res_valid_d), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(res_valid_d), 64'd0);
    chk("mid_rst_busy", 64'(busy_d), 64'd0);
    chk("mid_rst_xyz", 64'(xyz_d), 64'd0);
    chk("mid_rst_sel", 64'({sel1_d, sel2_d}), 64'd0);
    chk("mid_rst_res", 64'({res_xyz_d, res_data_d}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("mid_rst_no_done", 64'(done_d), 64'd0);
      step();
    end

    sel1_cfg_d = 3'd3;
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    chk("restart_sel1", 64'(sel1_d), 64'd3);
    wait_valid_d();
    chk("restart_xyz", 64'(res_xyz_d), 64'd0);
    chk("restart_data", 64'(res_data_d), 64'(model(14'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
